uart_transmit: RTL and testbench
================================

# uart_transmit

UART transmitter: the transmit-side counterpart of the design's oversampled UART receiver, sharing its `clk_sample` domain and its 16× oversampling convention. A host writes bytes through an active-low write strobe into a small FIFO. The block serialises each byte as one 8N1 frame on `txd`: start bit, 8 data bits LSB first, one stop bit. It sits between the host bus interface and the serial line pin.

## Interface
Parameters:
- `OVS`, default 16: `clk_sample` cycles per bit; legal range 2..256.
- `FIFO_AW`, default 2: FIFO address width; depth = 2^FIFO_AW = 4.

Ports:
- `clk_sample`, input, 1: sole clock; all logic on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `din`, input, 8: byte to transmit; sampled when `wrn` is low.
- `wrn`, input, 1: active-low write strobe; each cycle it is low at a rising edge writes one byte.
- `txd`, output, 1: serial line; idles high.
- `tx_busy`, output, 1: high while a frame is on the line, START through STOP.
- `tx_done`, output, 1: one-cycle pulse when a frame's stop bit completes.
- `full`, output, 1: FIFO holds 2^FIFO_AW entries.
- `empty`, output, 1: FIFO holds 0 entries.
- `overflow`, output, 1: sticky; set when a write is dropped; cleared only by `rst`.

## Operation
- **Reset values:** `txd`=1, `tx_busy`=0, `tx_done`=0, `full`=0, `empty`=1, `overflow`=0. FIFO pointers and count are 0; the FSM is in IDLE.
- **FIFO write:** a write is accepted iff `wrn`=0 and the registered `full`=0.
  - A write while `full`=1 is dropped and sets `overflow`.
  - A pop in the same cycle does not rescue the write.
- **Simultaneous push and pop:** the count is unchanged and both pointers advance.
- **Pointer wrap:** natural modulo 2^FIFO_AW. The count is FIFO_AW+1 bits wide.
- **FSM states** (one-hot: IDLE, START, DATA, STOP):
  - IDLE: `txd`=1. If `empty`=0, pop the head into an 8-bit shift register, clear the tick and bit counters, and go to START.
  - START: `txd`=0 for OVS cycles, then go to DATA.
  - DATA: `txd`=shift_reg[0]. After every OVS cycles, shift right and increment the 3-bit bit counter. After bit 7 completes, go to STOP.
  - STOP: `txd`=1 for OVS cycles. In the final cycle `tx_done`=1.
    - If `empty`=0 at that point, pop and go directly to START, with no idle bit between frames.
    - Otherwise go to IDLE.
- **Tick counter:** width clog2(OVS). It counts 0..OVS-1 and wraps; bit boundaries occur when tick = OVS-1.
- **Output registers:** `txd` and `tx_busy` are registered, so the line never glitches.
- **Reset mid-frame:** `txd` goes high immediately (asynchronously), the FIFO contents are discarded, and the frame is abandoned.
- **`din` sampling:** `din` is sampled only on accepted writes. It may change freely otherwise.

## Timing
- **Write to line latency:** a write accepted at edge E with the FSM in IDLE and the FIFO empty gives:
  - `empty`=0 after E;
  - pop at E+1;
  - `txd` falls after E+2;
  - `tx_busy` rises after E+2.
- **Frame length:** exactly 10·OVS cycles, from `txd` falling to the end of the stop bit.
- **`tx_done`:** high during the last stop-bit cycle, one cycle wide.
- **`tx_busy`:** falls after the edge ending STOP, unless the next frame starts back-to-back.
- **Flag update:** `full` and `empty` update on the edge after the push or pop.

## Structure
- **Shared package `uart_defs.vh`:**
  - FSM state encodings: one-hot localparams `TX_IDLE`, `TX_START`, `TX_DATA`, `TX_STOP`.
  - Frame constants: `UART_DATA_BITS`=8, `UART_STOP_BITS`=1.
  - Default `OVS`=16, shared with the receiver.
- **Sub-module `uart_tx_fifo`:** synchronous FIFO with parameter FIFO_AW.
  - Ports: `clk_sample`, `rst`, `push`, `wdata`, `pop`, `rdata`, `full`, `empty`.
  - `rdata` shows the head combinationally (first-word fall-through).
- **Top level:** contains the FSM, the tick counter, the bit counter, the shift register and the overflow flag.

## Test plan
All scenarios use OVS=16 and FIFO_AW=2.

1. **Single byte:** write 0x55 from idle. `txd` must carry 0,1,0,1,0,1,0,1,0,1, each level for 16 cycles, with the first bit starting 2 edges after the write. `tx_done` must pulse once at frame cycle 160. `empty`=1 and `tx_busy`=0 afterwards.
2. **Back-to-back frames:** write 0xA5 then 0x3C on consecutive cycles. The line must show two contiguous 160-cycle frames with no idle bit between them: 0 10100101 1 0 00111100 1, data LSB first. `tx_done` must pulse at cycles 160 and 320.
3. **Overflow:** from idle, write 0x01..0x06 on six consecutive cycles.
   - 0x01 is popped after its own write; 0x02..0x05 fill the FIFO, so `full`=1.
   - 0x06 is dropped and `overflow`=1.
   - Exactly five frames, 0x01..0x05, appear on the line, and `overflow` stays 1.
4. **Reset mid-frame:** assert `rst` during data bit 3 of 0xFF after 0x00 is queued.
   - `txd` must be 1 immediately and all outputs must take their reset values.
   - After `rst` is released, no frame may appear until a new write.
5. **Full then pop:** fill the FIFO, then hold `wrn`=0 in the cycle of the first pop. That write must be dropped, with `overflow`=1 and a count of 3 after the pop.
6. **Minimum OVS:** with OVS=2, write 0x80. The frame must be 20 cycles, with `txd` high only in the bit-7 and stop-bit periods.

Source files
------------

// File: rtl/uart_transmit_pkg.sv
// Shared UART definitions: frame constants, default oversampling and transmitter FSM encodings.
package uart_transmit_pkg;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam int unsigned UART_STOP_BITS   = 1;
    localparam int unsigned UART_OVS_DEFAULT = 16;

    typedef enum logic [3:0] {
        TX_IDLE  = 4'b0001,
        TX_START = 4'b0010,
        TX_DATA  = 4'b0100,
        TX_STOP  = 4'b1000
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// First-word fall-through transmit FIFO with registered full/empty flags.
module uart_tx_fifo
    import uart_transmit_pkg::*;
#(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic                      clk_sample,
    input  logic                      rst,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] wdata,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = FIFO_AW + 1;

    logic [UART_DATA_BITS-1:0] mem_q [DEPTH];
    logic [FIFO_AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      full_q, empty_q;
    logic                      push_ok, pop_ok;

    // Flags gate the requests so a stray push/pop can never corrupt the pointers.
    always_comb begin
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == CNT_W'(DEPTH));
            empty_q  <= (count_d == '0);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_sample) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_transmit.sv
// 8N1 UART transmitter: host write strobe into a small FIFO, oversampled serialiser onto txd.
module uart_transmit
    import uart_transmit_pkg::*;
#(
    parameter int unsigned OVS     = UART_OVS_DEFAULT,
    parameter int unsigned FIFO_AW = 2
) (
    input  logic                      clk_sample,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] din,
    input  logic                      wrn,
    output logic                      txd,
    output logic                      tx_busy,
    output logic                      tx_done,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow
);

    localparam int unsigned          TICK_W    = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [TICK_W-1:0]    TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [2:0]           BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_e                 state_q, state_d;
    logic [TICK_W-1:0]         tick_q, tick_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic [UART_DATA_BITS-1:0] fifo_rdata;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      tick_last;

    uart_tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk_sample (clk_sample),
        .rst        (rst),
        .push       (fifo_push),
        .wdata      (din),
        .pop        (fifo_pop),
        .rdata      (fifo_rdata),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign fifo_push = ~wrn & ~fifo_full;
    assign tick_last = (tick_q == TICK_LAST);

    // Next-state, datapath and output-register inputs.
    always_comb begin
        state_d    = state_q;
        tick_d     = tick_last ? '0 : tick_q + TICK_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        overflow_d = overflow_q | (~wrn & fifo_full);
        txd_d      = 1'b1;
        busy_d     = (state_q != TX_IDLE);
        done_d     = (state_q == TX_STOP) && tick_last;

        case (state_q)
            TX_IDLE: begin
                tick_d = tick_q;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    tick_d   = '0;
                    bit_d    = '0;
                    state_d  = TX_START;
                end
            end
            TX_START: begin
                txd_d = 1'b0;
                if (tick_last) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_d = shift_q[0];
                if (tick_last) begin
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                // Chain straight into the next start bit when more data is queued.
                if (tick_last) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        tick_d   = '0;
                        bit_d    = '0;
                        state_d  = TX_START;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sample or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd      = txd_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit: per-cycle line/flag model driven by a write schedule.
module tb_uart_transmit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din1, din2;
    logic       wrn1, wrn2;
    logic       txd1, busy1, done1, full1, empty1, ovf1;
    logic       txd2, busy2, done2, full2, empty2, ovf2;

    always #5 clk = ~clk;

    uart_transmit #(.OVS(16), .FIFO_AW(2)) dut1 (
        .clk_sample (clk), .rst (rst), .din (din1), .wrn (wrn1),
        .txd (txd1), .tx_busy (busy1), .tx_done (done1),
        .full (full1), .empty (empty1), .overflow (ovf1)
    );

    uart_transmit #(.OVS(2), .FIFO_AW(2)) dut2 (
        .clk_sample (clk), .rst (rst), .din (din2), .wrn (wrn2),
        .txd (txd2), .tx_busy (busy2), .tx_done (done2),
        .full (full2), .empty (empty2), .overflow (ovf2)
    );

    int total = 0;
    int bad   = 0;

    logic       stim_en  [4096];
    logic [7:0] stim_dat [4096];
    int         stim_len;

    function automatic string sig_name(input int s);
        case (s)
            5: return "txd";
            4: return "tx_busy";
            3: return "tx_done";
            2: return "full";
            1: return "empty";
            default: return "overflow";
        endcase
    endfunction

    // Line level of bit slot idx (0 start, 1..8 data LSB first, 9 stop).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    function automatic logic [5:0] outs(input bit sel);
        if (sel) return {txd2, busy2, done2, full2, empty2, ovf2};
        return {txd1, busy1, done1, full1, empty1, ovf1};
    endfunction

    task automatic clear_stim();
        for (int i = 0; i < 4096; i++) begin
            stim_en[i]  = 1'b0;
            stim_dat[i] = 8'h00;
        end
        stim_len = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        wrn1 = 1'b1;
        wrn2 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives the schedule (write at edge k) and compares every cycle against the model.
    task automatic run_seq(input int ovs, input bit sel, input string name);
        logic [7:0] q[$];
        logic [7:0] cur_byte = 8'h00;
        logic [7:0] popped;
        logic [5:0] got, expv;
        int         fl        = 10 * ovs;
        int         pt        = -1;
        int         next_free = 0;
        bit         ovf       = 1'b0;
        bit         finished  = 1'b0;
        bit         we, pop, acc, in_frame;
        int         nerr [6];
        int         fk   [6];
        logic       fg   [6];
        logic       fe   [6];
        for (int s = 0; s < 6; s++) begin
            nerr[s] = 0; fk[s] = 0; fg[s] = 1'b0; fe[s] = 1'b0;
        end
        for (int k = 0; k < 20000; k++) begin
            we = (k < stim_len) && stim_en[k];
            if (sel) begin
                wrn2 = ~we; din2 = we ? stim_dat[k] : 8'($urandom); wrn1 = 1'b1;
            end else begin
                wrn1 = ~we; din1 = we ? stim_dat[k] : 8'($urandom); wrn2 = 1'b1;
            end
            @(posedge clk);
            pop = (q.size() > 0) && (k >= next_free);
            acc = we && (q.size() < 4);
            if (we && !acc) ovf = 1'b1;
            in_frame = (pt >= 0) && (k > pt) && (k <= pt + fl);
            expv[5] = in_frame ? frame_bit(cur_byte, (k - pt - 1) / ovs) : 1'b1;
            expv[4] = in_frame;
            expv[3] = (pt >= 0) && (k == pt + fl);
            if (acc) q.push_back(we ? stim_dat[k] : 8'h00);
            if (pop) begin
                popped    = q.pop_front();
                cur_byte  = popped;
                pt        = k;
                next_free = k + fl;
            end
            expv[2] = (q.size() == 4);
            expv[1] = (q.size() == 0);
            expv[0] = ovf;
            @(negedge clk);
            got = outs(sel);
            for (int s = 0; s < 6; s++) begin
                if (got[s] !== expv[s]) begin
                    if (nerr[s] == 0) begin
                        fk[s] = k; fg[s] = got[s]; fe[s] = expv[s];
                    end
                    nerr[s]++;
                end
            end
            if (k >= stim_len && q.size() == 0 && (pt < 0 || k > pt + fl + 2)) begin
                finished = 1'b1;
                break;
            end
        end
        wrn1 = 1'b1;
        wrn2 = 1'b1;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s/drain: model still busy after cycle budget, got unfinished expected finished", name);
        end
        for (int s = 0; s < 6; s++) begin
            total++;
            if (nerr[s] != 0) begin
                bad++;
                $display("FAIL %s/%s: %0d cycles wrong, first at cycle %0d got %b expected %b",
                         name, sig_name(s), nerr[s], fk[s], fg[s], fe[s]);
            end
        end
    endtask

    task automatic test_reset();
        logic [5:0] got;
        logic [5:0] expv = 6'b100010;
        repeat (2) @(negedge clk);
        got = outs(1'b0);
        for (int s = 0; s < 6; s++) begin
            total++;
            if (got[s] !== expv[s]) begin
                bad++;
                $display("FAIL reset/%s: got %b expected %b", sig_name(s), got[s], expv[s]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        got = outs(1'b1);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL reset_ovs2: got %b expected %b", got, expv);
        end
    endtask

    task automatic test_single_byte();
        do_reset(); clear_stim();
        stim_en[0] = 1'b1; stim_dat[0] = 8'h55; stim_len = 1;
        run_seq(16, 1'b0, "single");
    endtask

    task automatic test_back_to_back();
        do_reset(); clear_stim();
        stim_en[0] = 1'b1; stim_dat[0] = 8'hA5;
        stim_en[1] = 1'b1; stim_dat[1] = 8'h3C; stim_len = 2;
        run_seq(16, 1'b0, "back_to_back");
    endtask

    task automatic test_overflow();
        do_reset(); clear_stim();
        for (int i = 0; i < 6; i++) begin
            stim_en[i] = 1'b1; stim_dat[i] = 8'(i + 1);
        end
        stim_len = 6;
        run_seq(16, 1'b0, "overflow");
    endtask

    task automatic test_full_then_pop();
        do_reset(); clear_stim();
        for (int i = 0; i < 5; i++) begin
            stim_en[i] = 1'b1; stim_dat[i] = 8'(8'h11 + i);
        end
        // First pop out of the full FIFO happens at the end of the first frame.
        stim_en[161] = 1'b1; stim_dat[161] = 8'h99;
        stim_len = 162;
        run_seq(16, 1'b0, "full_then_pop");
    endtask

    task automatic test_reset_midframe();
        logic [5:0] got;
        logic [5:0] expv = 6'b100010;
        int         errs = 0;
        do_reset();
        wrn1 = 1'b0; din1 = 8'hFF;
        @(negedge clk);
        wrn1 = 1'b0; din1 = 8'h00;
        @(negedge clk);
        wrn1 = 1'b1;
        repeat (69) @(negedge clk);
        total++;
        if (busy1 !== 1'b1) begin
            bad++;
            $display("FAIL midframe_busy: got %b expected 1", busy1);
        end
        rst = 1'b1;
        #1;
        got = outs(1'b0);
        for (int s = 0; s < 6; s++) begin
            total++;
            if (got[s] !== expv[s]) begin
                bad++;
                $display("FAIL midframe_reset/%s: got %b expected %b", sig_name(s), got[s], expv[s]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (outs(1'b0) !== expv) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL post_reset_quiet: %0d cycles not idle, expected 0", errs);
        end
        clear_stim();
        stim_en[0] = 1'b1; stim_dat[0] = 8'h5A; stim_len = 1;
        run_seq(16, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            do_reset(); clear_stim();
            stim_len = 900;
            for (int k = 0; k < stim_len; k++) begin
                stim_en[k]  = ($urandom_range(0, 99) < 3);
                stim_dat[k] = 8'($urandom);
            end
            run_seq(16, 1'b0, $sformatf("random%0d", it));
        end
        do_reset(); clear_stim();
        stim_len = $urandom_range(1, 8);
        for (int k = 0; k < stim_len; k++) begin
            stim_en[k] = 1'b1; stim_dat[k] = 8'($urandom);
        end
        run_seq(16, 1'b0, "random_burst");
    endtask

    task automatic test_min_ovs();
        do_reset(); clear_stim();
        stim_en[0] = 1'b1; stim_dat[0] = 8'h80; stim_len = 1;
        run_seq(2, 1'b1, "ovs2_single");
        do_reset(); clear_stim();
        stim_len = 120;
        for (int k = 0; k < stim_len; k++) begin
            stim_en[k]  = ($urandom_range(0, 99) < 15);
            stim_dat[k] = 8'($urandom);
        end
        run_seq(2, 1'b1, "ovs2_random");
    endtask

    initial begin
        rst  = 1'b1;
        wrn1 = 1'b1;
        wrn2 = 1'b1;
        din1 = 8'h00;
        din2 = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_full_then_pop();
        test_reset_midframe();
        test_random();
        test_min_ovs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
